alarm_event_reporter: RTL and testbench

Sits downstream of the security-alarm FSM and consumes its 2-bit state code and alarm bit. Detects every change of {state, alarm} and packs each change into an event byte. Events queue in a small FIFO and go out to a monitoring host over a UART 8N1 transmit line. This is the reporting end of the alarm FSM's status interface.

---
 rtl/alarm_pkg.sv | 17 +
 rtl/uart_tx_8n1.sv | 91 +++++++++
 rtl/alarm_event_reporter.sv | 95 +++++++++
 tb/tb_alarm_event_reporter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm FSM status interface: state codes and event-byte layout.
package alarm_pkg;

  localparam logic [1:0] ST_OFF       = 2'b00;
  localparam logic [1:0] ST_ARMED     = 2'b01;
  localparam logic [1:0] ST_TRIGGERED = 2'b10;
  localparam logic [1:0] ST_ALARM_ON  = 2'b11;

  // Event byte, MSB first: previous state, new state, new alarm bit, sequence number.
  typedef struct packed {
    logic [1:0] from_st;
    logic [1:0] to_st;
    logic       alarm;
    logic [2:0] seq;
  } event_t;

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter: accepts a byte when ready (IDLE), frame is 10*CLKS_PER_BIT cycles.
// tx falls on the accepting edge; ready stays low until the STOP bit has completed.
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign ready   = (state == S_IDLE);
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            shreg <= data;
            state <= S_START;
            cnt   <= '0;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // STOP: line already high; release busy so the next byte can start one cycle later.
          if (bit_end) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/alarm_event_reporter.sv
// Turns every {state, alarm} change of the alarm FSM into an event byte, queues it, sends it over UART.
// Push at the detecting edge, tx falls one edge later when idle; a push into a full FIFO without a pop is dropped and sets ovf.
module alarm_event_reporter
  import alarm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int AW          = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  st_in,
  input  logic        alarm_in,
  input  logic        ovf_clr,
  output logic        tx,
  output logic        busy,
  output logic        ovf,
  output logic [AW:0] fifo_level
);

  logic [1:0]    last_st;
  logic          last_alarm;
  logic [2:0]    seq;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          change;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic          tx_ready;
  event_t        ev;

  always_comb begin
    ev         = '0;
    ev.from_st = last_st;
    ev.to_st   = st_in;
    ev.alarm   = alarm_in;
    ev.seq     = seq;
  end

  assign change = ({st_in, alarm_in} != {last_st, last_alarm});
  assign full   = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign empty  = (fifo_level == '0);
  assign pop    = tx_ready && !empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_st    <= ST_OFF;
      last_alarm <= 1'b0;
      seq        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (change) begin
        last_st    <= st_in;
        last_alarm <= alarm_in;
        seq        <= seq + 3'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev;
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (mem[rd_ptr]),
    .valid(!empty),
    .ready(tx_ready),
    .tx   (tx),
    .busy (busy)
  );

endmodule

// File: tb/tb_alarm_event_reporter.sv
// Directed bench for alarm_event_reporter: vector table for the arm sequence plus hand-written corner sequences.
module tb_alarm_event_reporter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] st_in = 2'b00;
  logic       alarm_in = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic       ovf;
  logic [2:0] fifo_level;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_q[$];
  int         busy_len_q[$];
  int         frame_err = 0;

  typedef struct {
    logic [1:0] st;
    logic       alarm;
    logic [2:0] exp_level;
    logic [7:0] exp_byte;
  } arm_vec_t;

  arm_vec_t arm_tbl[4];

  alarm_event_reporter #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_in     (st_in),
    .alarm_in  (alarm_in),
    .ovf_clr   (ovf_clr),
    .tx        (tx),
    .busy      (busy),
    .ovf       (ovf),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Serial receiver model: samples mid-bit on the falling clock edge.
  bit         mon_active = 0;
  int         mon_pos = 0;
  int         busy_run = 0;
  logic [7:0] mon_byte = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_active = 0;
      mon_pos    = 0;
      busy_run   = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        busy_len_q.push_back(busy_run);
        busy_run = 0;
      end
      if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1;
          mon_pos    = 0;
        end
      end else begin
        mon_pos++;
      end
      if (mon_active) begin
        if (mon_pos % 16 == 8) begin
          int idx;
          idx = mon_pos / 16;
          if (idx == 0 && tx !== 1'b0) frame_err++;
          else if (idx >= 1 && idx <= 8) mon_byte[idx-1] = tx;
          else if (idx == 9 && tx !== 1'b1) frame_err++;
        end
        if (mon_pos == 159) begin
          mon_active = 0;
          rx_q.push_back(mon_byte);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n    = 1'b0;
    st_in    = 2'b00;
    alarm_in = 1'b0;
    ovf_clr  = 1'b0;
    repeat (2) step();
    rx_q.delete();
    busy_len_q.delete();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check("rx frame count", rx_q.size(), n);
  endtask

  task automatic check_rx(input string name, input int i, input logic [7:0] exp);
    if (rx_q.size() > i) check(name, rx_q[i], exp);
    else check(name, 32'hDEAD, exp);
  endtask

  initial begin
    logic [7:0] exp_ovf[6];
    logic [7:0] exp_full[6];
    logic       a;
    int         n;
    int         c;

    arm_tbl[0] = '{st: 2'b01, alarm: 1'b0, exp_level: 3'd1, exp_byte: 8'h10};
    arm_tbl[1] = '{st: 2'b10, alarm: 1'b0, exp_level: 3'd1, exp_byte: 8'h61};
    arm_tbl[2] = '{st: 2'b11, alarm: 1'b0, exp_level: 3'd1, exp_byte: 8'hB2};
    arm_tbl[3] = '{st: 2'b11, alarm: 1'b1, exp_level: 3'd1, exp_byte: 8'hFB};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset ovf", ovf, 0);
    check("reset level", fifo_level, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Arm sequence, 200 cycles per step
    for (int i = 0; i < 4; i++) begin
      st_in    = arm_tbl[i].st;
      alarm_in = arm_tbl[i].alarm;
      step();
      check("arm level after push", fifo_level, arm_tbl[i].exp_level);
      repeat (199) step();
      check("arm busy between frames", busy, 0);
      check("arm tx idle between frames", tx, 1);
    end
    wait_rx(4, 400);
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      check_rx("arm byte", i, arm_tbl[i].exp_byte);
      if (busy_len_q.size() > i) check("arm frame length", busy_len_q[i], 160);
      else check("arm frame length", 0, 160);
    end
    check("arm ovf", ovf, 0);

    // Latency: push at edge k, pop and tx low at edge k+1
    do_reset();
    st_in = 2'b01;
    step();
    check("lat level after k", fifo_level, 1);
    check("lat tx after k", tx, 1);
    step();
    check("lat tx after k+1", tx, 0);
    check("lat level after k+1", fifo_level, 0);
    check("lat busy after k+1", busy, 1);
    repeat (170) step();
    st_in = 2'b00;
    step();
    step();
    n = 0;
    while (tx == 1'b0 && n < 40) begin
      n++;
      step();
    end
    check("start bit length", n, 16);
    wait_rx(2, 300);
    check_rx("lat byte 0", 0, 8'h10);
    check_rx("lat byte 1", 1, 8'h41);

    // Overflow: six changes on consecutive edges
    do_reset();
    exp_ovf = '{8'h10, 8'h61, 8'hB2, 8'hC3, 8'h14, 8'hB6};
    begin
      logic [1:0] seq_st[6];
      seq_st = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
      for (int i = 0; i < 6; i++) begin
        st_in = seq_st[i];
        step();
        if (i == 4) check("ovf level full", fifo_level, 4);
        if (i == 4) check("ovf not yet", ovf, 0);
      end
    end
    check("ovf level after drop", fifo_level, 4);
    check("ovf set on drop", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf cleared", ovf, 0);
    wait_rx(5, 1200);
    repeat (5) step();
    st_in = 2'b11;
    wait_rx(6, 400);
    for (int i = 0; i < 6; i++) check_rx("ovf byte", i, exp_ovf[i]);
    check("ovf stays clear", ovf, 0);

    // Full FIFO with push and pop on the same edge
    do_reset();
    exp_full = '{8'h10, 8'h61, 8'hB2, 8'hC3, 8'h14, 8'h65};
    begin
      logic [1:0] seq_st[5];
      seq_st = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
      for (int i = 0; i < 5; i++) begin
        st_in = seq_st[i];
        step();
      end
    end
    check("full level", fifo_level, 4);
    c = 0;
    while (busy && c < 400) begin
      step();
      c++;
    end
    check("full frame ended", busy, 0);
    check("full level at stop end", fifo_level, 4);
    st_in = 2'b10;
    step();
    check("full push+pop level", fifo_level, 4);
    check("full push+pop ovf", ovf, 0);
    check("full push+pop busy", busy, 1);
    st_in = 2'b11;
    step();
    check("full drop ovf", ovf, 1);
    st_in   = 2'b00;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr with drop keeps ovf", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr alone clears ovf", ovf, 0);
    wait_rx(6, 1200);
    for (int i = 0; i < 6; i++) check_rx("full byte", i, exp_full[i]);

    // Reset during DATA bit 3
    do_reset();
    st_in = 2'b01;
    step();
    step();
    st_in = 2'b10;
    step();
    repeat (68) step();
    rst_n = 1'b0;
    #1;
    check("mid reset tx", tx, 1);
    check("mid reset busy", busy, 0);
    check("mid reset level", fifo_level, 0);
    st_in = 2'b00;
    repeat (2) step();
    rx_q.delete();
    busy_len_q.delete();
    rst_n = 1'b1;
    step();
    st_in    = 2'b11;
    alarm_in = 1'b1;
    wait_rx(1, 400);
    check_rx("post reset byte", 0, 8'h38);

    // Sequence number wrap over nine events
    do_reset();
    a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a        = ~a;
      alarm_in = a;
      step();
      repeat (169) step();
      check_rx("seq wrap byte", i, {4'b0000, a, 3'(i % 8)});
    end

    check("framing errors", frame_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
